// File: rtl/dvs_evt_gen.sv
// Emulated DVS event source: walks {chan, y, x, pol} and emits one keyed event per period.
// Optional drop counter (tick lost while an event is pending) when DVS_EVT_GEN_DROP_CNT_EN is defined.
module dvs_evt_gen #(
   parameter int NCH      = 2,
   parameter int XBITS    = 8,
   parameter int YBITS    = 8,
   parameter int PERIOD_W = 16,
   parameter int CBITS    = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                enable_in,
   input  logic [PERIOD_W-1:0] period_in,
   input  logic [31:0]         key_base_in,
   output logic [31:0]         evt_data_out,
   output logic                evt_vld_out,
   input  logic                evt_rdy_in,
   output logic [CBITS-1:0]    evt_chan_out,
`ifdef DVS_EVT_GEN_DROP_CNT_EN
   output logic [15:0]         drop_cnt_out,
`endif
   output logic [31:0]         evt_cnt_out
);

   localparam int                  PBITS   = 1 + XBITS + YBITS + CBITS;
   localparam logic [CBITS-1:0]    CH_LAST = CBITS'(NCH - 1);
   localparam logic [CBITS-1:0]    CH_ONE  = CBITS'(1'b1);
   localparam logic [XBITS-1:0]    X_ONE   = XBITS'(1'b1);
   localparam logic [YBITS-1:0]    Y_ONE   = YBITS'(1'b1);
   localparam logic [PERIOD_W-1:0] P_ONE   = PERIOD_W'(1'b1);
   localparam logic [PERIOD_W-1:0] P_ZERO  = {PERIOD_W{1'b0}};
`ifdef DVS_EVT_GEN_DROP_CNT_EN
   localparam bit CNT_IN_SEND = 1'b1;
`else
   localparam bit CNT_IN_SEND = 1'b0;
`endif

   generate
      if (PBITS > 32) begin : g_key_width_check
         $error("dvs_evt_gen: 1 + XBITS + YBITS + CBITS must not exceed 32");
      end
      if ((NCH < 1) || (NCH > 16)) begin : g_nch_check
         $error("dvs_evt_gen: NCH must be in 1..16");
      end
   endgenerate

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_SEND = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [PERIOD_W-1:0] r_period_cnt;
   logic [PERIOD_W-1:0] w_limit_m1;
   logic                w_cnt_run;
   logic                w_tick;
   logic                w_hs;
   logic                w_capture;
   logic [CBITS-1:0]    r_chan;
   logic [XBITS-1:0]    r_x;
   logic [YBITS-1:0]    r_y;
   logic                r_pol;
   logic [PBITS-1:0]    w_pos;
   logic [31:0]         r_data;
   logic [CBITS-1:0]    r_chan_out;
   logic [31:0]         r_evt_cnt;
`ifdef DVS_EVT_GEN_DROP_CNT_EN
   logic [15:0]         r_drop_cnt;
`endif

   // Period 0 behaves as 1; >= lets a shortened period tick at once.
   always_comb begin
      w_limit_m1 = (period_in == P_ZERO) ? P_ZERO : (period_in - P_ONE);
      w_cnt_run  = (r_state == S_WAIT) || (CNT_IN_SEND && (r_state == S_SEND));
      w_tick     = w_cnt_run && (r_period_cnt >= w_limit_m1);
      w_hs       = (r_state == S_SEND) && evt_rdy_in;
      w_capture  = (r_state == S_WAIT) && (w_next == S_SEND);
      w_pos      = {r_chan, r_y, r_x, r_pol};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (enable_in) w_next = S_WAIT;
            else           w_next = S_IDLE;
         end
         S_WAIT: begin
            if (!enable_in)  w_next = S_IDLE;
            else if (w_tick) w_next = S_SEND;
            else             w_next = S_WAIT;
         end
         S_SEND: begin
            if (w_hs) w_next = enable_in ? S_WAIT : S_IDLE;
            else      w_next = S_SEND;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_period_cnt <= P_ZERO;
      end else if (w_next == S_IDLE) begin
         r_period_cnt <= P_ZERO;
      end else if (w_cnt_run) begin
         r_period_cnt <= w_tick ? P_ZERO : (r_period_cnt + P_ONE);
      end else begin
         r_period_cnt <= r_period_cnt;
      end
   end

   // Odometer-style advance: chan, then x, then y, then polarity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_chan <= {CBITS{1'b0}};
         r_x    <= {XBITS{1'b0}};
         r_y    <= {YBITS{1'b0}};
         r_pol  <= 1'b0;
      end else if (w_hs) begin
         if (r_chan == CH_LAST) begin
            r_chan <= {CBITS{1'b0}};
            r_x    <= r_x + X_ONE;
            if (&r_x) begin
               r_y <= r_y + Y_ONE;
               if (&r_y) r_pol <= ~r_pol;
            end
         end else begin
            r_chan <= r_chan + CH_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data     <= 32'd0;
         r_chan_out <= {CBITS{1'b0}};
         r_evt_cnt  <= 32'd0;
      end else begin
         if (w_capture) begin
            r_data     <= key_base_in | 32'(w_pos);
            r_chan_out <= r_chan;
         end
         if (w_hs) r_evt_cnt <= r_evt_cnt + 32'd1;
      end
   end

`ifdef DVS_EVT_GEN_DROP_CNT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_drop_cnt <= 16'd0;
      end else if ((r_state == S_SEND) && w_tick && (r_drop_cnt != 16'hFFFF)) begin
         r_drop_cnt <= r_drop_cnt + 16'd1;
      end
   end
`endif

   always_comb begin
      evt_vld_out  = (r_state == S_SEND);
      evt_data_out = r_data;
      evt_chan_out = r_chan_out;
      evt_cnt_out  = r_evt_cnt;
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      drop_cnt_out = r_drop_cnt;
`endif
   end

endmodule

// File: tb/tb_dvs_evt_gen.sv
// Directed + randomized bench for dvs_evt_gen with a position-index reference model.
module tb_dvs_evt_gen;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_a, rdy_a, en_b, rdy_b;
   logic [15:0] per_a, per_b;
   logic [31:0] key_a, key_b;
   logic [31:0] data_a, data_b, cnt_a, cnt_b;
   logic        vld_a, vld_b;
   logic [0:0]  chan_a, chan_b;
`ifdef DVS_EVT_GEN_DROP_CNT_EN
   logic [15:0] drop_a, drop_b;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dvs_evt_gen #(.NCH(2), .XBITS(8), .YBITS(8), .PERIOD_W(16)) u_a (
      .clk(clk), .reset(reset), .enable_in(en_a), .period_in(per_a), .key_base_in(key_a),
      .evt_data_out(data_a), .evt_vld_out(vld_a), .evt_rdy_in(rdy_a), .evt_chan_out(chan_a),
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      .drop_cnt_out(drop_a),
`endif
      .evt_cnt_out(cnt_a)
   );

   dvs_evt_gen #(.NCH(1), .XBITS(1), .YBITS(1), .PERIOD_W(16)) u_b (
      .clk(clk), .reset(reset), .enable_in(en_b), .period_in(per_b), .key_base_in(key_b),
      .evt_data_out(data_b), .evt_vld_out(vld_b), .evt_rdy_in(rdy_b), .evt_chan_out(chan_b),
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      .drop_cnt_out(drop_b),
`endif
      .evt_cnt_out(cnt_b)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Counts edges until the selected instance shows valid, bounded by limit.
   task automatic wait_vld(input bit use_b, input int limit, output int n);
      n = 0;
      do begin
         step(1);
         n++;
      end while (!(use_b ? vld_b : vld_a) && (n < limit));
      check("vld_seen", 32'(use_b ? vld_b : vld_a), 32'd1);
   endtask

   // Key of the k-th event: position index decomposed as chan, x, y, pol digits.
   function automatic logic [31:0] model_key(input int k, input int nch, input int xb,
                                             input int yb, input logic [31:0] base);
      int r, ch, x, y, p;
      ch = k % nch;
      r  = k / nch;
      x  = r % (1 << xb);
      r  = r / (1 << xb);
      y  = r % (1 << yb);
      r  = r / (1 << yb);
      p  = r % 2;
      return base | (32'(ch) << (1 + xb + yb)) | (32'(y) << (1 + xb)) | (32'(x) << 1) | 32'(p);
   endfunction

   function automatic int eff(input logic [15:0] p);
      return (p == 16'd0) ? 1 : int'(p);
   endfunction

   task automatic check_lat(input string tag, input int n, input int exp);
`ifndef DVS_EVT_GEN_DROP_CNT_EN
      check(tag, 32'(n), 32'(exp));
`endif
   endtask

   initial begin
      int n, acc, d;
      logic [31:0] hold;
      logic [31:0] exp29 [8];
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      logic [15:0] drop0;
`endif
      exp29 = '{32'd0, 32'd2, 32'd4, 32'd6, 32'd1, 32'd3, 32'd5, 32'd7};
      acc = 0;
      reset = 1'b1;
      en_a = 1'b0; rdy_a = 1'b0; per_a = 16'd4; key_a = 32'd0;
      en_b = 1'b0; rdy_b = 1'b0; per_b = 16'd0; key_b = 32'd0;
      step(2);
      check("rst_vld_a", 32'(vld_a), 32'd0);
      check("rst_data_a", data_a, 32'd0);
      check("rst_chan_a", 32'(chan_a), 32'd0);
      check("rst_cnt_a", cnt_a, 32'd0);
      check("rst_vld_b", 32'(vld_b), 32'd0);
      reset = 1'b0;
      step(1);

      // Basic sequence with fixed key base and period 4.
      key_a = 32'h8000_0000; per_a = 16'd4; rdy_a = 1'b1; en_a = 1'b1;
      for (int e = 0; e < 3; e++) begin
         wait_vld(1'b0, 100, n);
         check_lat("lat_basic", n, 5);
         check("data_basic", data_a, model_key(acc, 2, 8, 8, key_a));
         check("chan_basic", 32'(chan_a), 32'(acc % 2));
         check("cnt_basic", cnt_a, 32'(acc));
         acc++;
      end
      acc--;

      // Random period, key base and back-pressure; data must hold while stalled.
      for (int e = 0; e < 12; e++) begin
         d = $urandom_range(0, 3);
         rdy_a = 1'b0;
         hold = data_a;
         key_a = $urandom;
         per_a = 16'($urandom_range(0, 6));
         for (int s = 0; s < d; s++) begin
            step(1);
            check("rnd_vld_hold", 32'(vld_a), 32'd1);
            check("rnd_data_hold", data_a, hold);
         end
         rdy_a = 1'b1;
         acc++;
         wait_vld(1'b0, 100, n);
         check_lat("lat_rnd", n, eff(per_a) + 1);
         check("data_rnd", data_a, model_key(acc, 2, 8, 8, key_a));
         check("cnt_rnd", cnt_a, 32'(acc));
      end

      // Period shortened mid-WAIT below the running count ticks immediately.
      per_a = 16'd6;
      step(1);
      acc++;
      step(3);
      check("short_vld_lo", 32'(vld_a), 32'd0);
      per_a = 16'd2;
      step(1);
      check("short_vld_hi", 32'(vld_a), 32'd1);
      check("short_data", data_a, model_key(acc, 2, 8, 8, key_a));

      // Long stall with period 4.
      per_a = 16'd4;
      rdy_a = 1'b0;
      hold = data_a;
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      drop0 = drop_a;
`endif
      for (int s = 0; s < 20; s++) begin
         step(1);
         check("stall_vld", 32'(vld_a), 32'd1);
         check("stall_data", data_a, hold);
      end
`ifdef DVS_EVT_GEN_DROP_CNT_EN
      check("stall_drop", 32'(drop_a - drop0), 32'd5);
`endif
      rdy_a = 1'b1;
      acc++;
      wait_vld(1'b0, 100, n);
      check_lat("lat_stall", n, 5);
      check("data_stall", data_a, model_key(acc, 2, 8, 8, key_a));

      // Enable dropped in WAIT: back to idle, position kept.
      step(1);
      acc++;
      step(1);
      en_a = 1'b0;
      for (int s = 0; s < 6; s++) begin
         step(1);
         check("wdrop_idle", 32'(vld_a), 32'd0);
      end
      en_a = 1'b1;
      wait_vld(1'b0, 100, n);
      check_lat("lat_wdrop", n, 5);
      check("data_wdrop", data_a, model_key(acc, 2, 8, 8, key_a));

      // Enable dropped in SEND: pending event still delivered, then idle.
      rdy_a = 1'b0;
      en_a = 1'b0;
      step(3);
      check("sdrop_vld", 32'(vld_a), 32'd1);
      rdy_a = 1'b1;
      step(1);
      acc++;
      check("sdrop_after", 32'(vld_a), 32'd0);
      check("sdrop_cnt", cnt_a, 32'(acc));
      for (int s = 0; s < 6; s++) begin
         step(1);
         check("sdrop_idle", 32'(vld_a), 32'd0);
      end
      en_a = 1'b1;
      wait_vld(1'b0, 100, n);
      check_lat("lat_sdrop", n, 5);
      check("data_sdrop", data_a, model_key(acc, 2, 8, 8, key_a));

      // Asynchronous reset while an event is pending.
      rdy_a = 1'b0;
      #3;
      reset = 1'b1;
      #1;
      check("arst_vld", 32'(vld_a), 32'd0);
      check("arst_cnt", cnt_a, 32'd0);
      check("arst_data", data_a, 32'd0);
      step(1);
      reset = 1'b0;
      rdy_a = 1'b1;
      acc = 0;
      wait_vld(1'b0, 100, n);
      check_lat("lat_arst", n, 5);
      check("data_arst", data_a, key_a);
      check("cnt_arst", cnt_a, 32'd0);
      en_a = 1'b0;

      // 2x2 frame, single channel, period 0 acting as 1.
      en_b = 1'b1; rdy_b = 1'b1; per_b = 16'd0; key_b = 32'd0;
      for (int k = 0; k < 8; k++) begin
         wait_vld(1'b1, 50, n);
         check("lat_frame", 32'(n), 32'd2);
         check("data_frame", data_b, exp29[k]);
         check("chan_frame", 32'(chan_b), 32'd0);
      end
      step(1);
      check("cnt_frame", cnt_b, 32'd8);
      en_b = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
